// File: rtl/parity_pkg.sv
// parity_pkg: parity sense constants and error counter width shared by parity_stream.
package parity_pkg;
    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD = 1'b1;
    localparam int ERR_CNT_W = 16;
endpackage

// File: rtl/parity_tree.sv
// parity_tree: combinational XOR-reduce of a W-bit word.
module parity_tree #(
    parameter int W = 8
) (
    input  logic [W-1:0] d,
    output logic         p
);
    assign p = ^d;
endmodule

// File: rtl/parity_stream.sv
// parity_stream: one-entry registered stream stage adding per-beat and per-packet parity with optional check.
// Defining PARITY_STREAM_ERR_CNT_EN adds a saturating err_cnt output counting flagged beats.
module parity_stream
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter bit ODD = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_par,
    input  logic              chk_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_par,
    output logic              m_pkt_par,
    output logic              m_err
`ifdef PARITY_STREAM_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);
    logic p, acc, acc_nx, bit_par, err_nx, take;
    parity_tree #(.W(DATA_W)) u_tree (.d(s_data), .p(p));
    // Ready is forced high in reset so upstream never sees a stall from a stale output beat.
    assign s_ready = !rst_n || !m_valid || m_ready;
    assign take = s_valid && s_ready;
    assign acc_nx = acc ^ p;
    assign bit_par = p ^ ODD;
    assign err_nx = chk_en && (s_par != bit_par);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data <= '0;
            m_last <= 1'b0;
            m_par <= 1'b0;
            m_pkt_par <= 1'b0;
            m_err <= 1'b0;
            acc <= 1'b0;
        end else if (take) begin
            m_valid <= 1'b1;
            m_data <= s_data;
            m_last <= s_last;
            m_par <= bit_par;
            m_pkt_par <= acc_nx ^ ODD;
            m_err <= err_nx;
            acc <= s_last ? 1'b0 : acc_nx;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end
`ifdef PARITY_STREAM_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (take && err_nx && err_cnt != '1)
            err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
`endif
endmodule

// File: doc/parity_stream.md
PARITY_STREAM -- requirements
Module: parity_stream

Interface
REQ-001 Parameter DATA_W, default 8, beat data width in bits (legal range 1..64).
REQ-002 Parameter ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  synchronous active-low reset.
REQ-006 Port s_valid  input  1  input beat valid.
REQ-007 Port s_ready  output  1  input beat accepted when s_valid && s_ready.
REQ-008 Port s_data  input  DATA_W  input beat data.
REQ-009 Port s_last  input  1  final beat of packet.
REQ-010 Port s_par  input  1  received parity bit, compared in check mode.
REQ-011 Port chk_en  input  1  1 = check mode, 0 = generate only; sampled per accepted beat.
REQ-012 Port m_valid  output  1  output beat valid.
REQ-013 Port m_ready  input  1  downstream accepts when m_valid && m_ready.
REQ-014 Port m_data  output  DATA_W  registered copy of s_data.
REQ-015 Port m_last  output  1  registered copy of s_last.
REQ-016 Port m_par  output  1  per-beat parity of m_data.
REQ-017 Port m_pkt_par  output  1  cumulative packet parity; meaningful only when m_last=1.
REQ-018 Port m_err  output  1  beat parity mismatch flag (check mode).

Function
REQ-019 One-entry registered output stage; s_ready = !m_valid || m_ready (combinational, no s_valid dependency).
REQ-020 Latency: beat accepted on edge N appears on m_* after edge N, one cycle.
REQ-021 Per-beat parity: m_par = XOR of all s_data bits, XOR ODD.
REQ-022 Accumulator acc (1 bit): on accepted beat, acc_next = acc XOR (XOR-reduce s_data); m_pkt_par = acc_next XOR ODD.
REQ-023 Accepted beat with s_last=1 clears acc to 0 after that edge; the next beat starts a new packet.
REQ-024 Single-beat packet (s_last on first beat): m_pkt_par = m_par.
REQ-025 m_err = chk_en && (s_par != per-beat parity), registered with the beat; 0 when chk_en=0.
REQ-026 Backpressure: while m_valid && !m_ready, all m_* outputs and acc SHALL hold.
REQ-027 Simultaneous output drain and input accept in the same cycle: new beat loads; no bubble, no loss.
REQ-028 m_valid clears on drain when no new beat is accepted in that cycle.

Reset
REQ-029 On rst_n=0 at a clock edge: m_valid=0, m_data=0, m_last=0, m_par=0, m_pkt_par=0, m_err=0, acc=0, error counter=0.
REQ-030 Reset mid-packet SHALL discard the partial packet; the first beat after reset starts a new packet.
REQ-031 s_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-032 Macro PARITY_STREAM_ERR_CNT_EN defined: adds output err_cnt (16 bits), incremented on each accepted beat whose m_err will be 1, saturating at 0xFFFF, cleared only by reset.
REQ-033 Macro PARITY_STREAM_ERR_CNT_EN undefined: port err_cnt and counter SHALL be absent; all other behaviour identical.

Structure
REQ-034 Package parity_pkg SHALL hold the ODD/EVEN parameter constants and the err_cnt width constant (16).
REQ-035 Sub-module parity_tree: combinational XOR-reduce of a parameterised width, instantiated once for s_data.

Verification
REQ-036 DATA_W=8, ODD=0, m_ready=1, single beats 0x00, 0x01, 0xFF, 0x80 with last=1 -> m_par = 0, 1, 0, 1 one cycle later; m_pkt_par equal to m_par.
REQ-037 Packet 0x03, 0x01, 0x07 with last on the third beat -> m_pkt_par on the last beat = 0 XOR 1 XOR 1 = 0; ODD=1 build -> 1.
REQ-038 chk_en=1, beat 0x01 with s_par=0 -> m_err=1 and err_cnt goes 0->1 when the macro is defined; same beat with s_par=1 -> m_err=0.
REQ-039 m_ready held low for 5 cycles with s_valid high -> one beat captured, s_ready=0, outputs stable; m_ready high -> back-to-back beats at one per cycle, no duplicate or lost beat.
REQ-040 rst_n low for one cycle after 2 beats of a 4-beat packet -> all outputs 0, acc cleared; new packet 0x01 with last -> m_pkt_par=1.
REQ-041 Exhaustive sweep over DATA_W=3, all 8 values -> m_par matches XOR-reduce on every beat.
